// File: rtl/pipe_adder32.sv
// pipe_adder32: segmented, pipelined adder/subtractor.
// Operands are cut into SEG-bit segments. Stage k adds segment k and registers
// its carry for stage k+1. Upper operand segments travel alongside so that each
// one reaches its stage together with its carry. The result bits collected so
// far travel the same way, so the final stage presents the whole word at once.
// One global enable advances every stage, which gives a valid/ready handshake
// with a throughput of one operation per clock.

module pipe_adder32 #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             in_carry,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int NSEG = WIDTH / SEG;

  if (SEG < 1 || SEG > WIDTH || (WIDTH % SEG) != 0) begin : g_bad_param
    $error("pipe_adder32: WIDTH must be a positive multiple of SEG");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtract is add of the inverted operand with the inverted borrow-in.
  assign b_eff   = in2 ^ {WIDTH{in_sub}};
  assign cin_eff = in_carry ^ in_sub;

  // The whole pipe moves only when the output slot is free or being drained.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // One segment of the sum; the top bit is the segment carry-out.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           c);
    seg_add = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c};
  endfunction

  for (genvar k = 0; k < NSEG; k++) begin : stg
    localparam int RW = (k + 1) * SEG;  // result bits known after this stage
    localparam int UW = WIDTH - RW;     // operand bits still waiting

    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic           c_in;
    logic           v_in;
    logic [SEG:0]   sum;
    logic [RW-1:0]  res_nxt;

    logic           vld_p;
    logic           carry_p;
    logic [RW-1:0]  res_p;

    if (k == 0) begin : g_src
      assign a_seg = in1[SEG-1:0];
      assign b_seg = b_eff[SEG-1:0];
      assign c_in  = cin_eff;
      assign v_in  = in_valid;
    end else begin : g_src
      assign a_seg = stg[k-1].g_skew.a_p[SEG-1:0];
      assign b_seg = stg[k-1].g_skew.b_p[SEG-1:0];
      assign c_in  = stg[k-1].carry_p;
      assign v_in  = stg[k-1].vld_p;
    end

    assign sum = seg_add(a_seg, b_seg, c_in);

    if (k == 0) begin : g_res
      assign res_nxt = sum[SEG-1:0];
    end else begin : g_res
      assign res_nxt = {sum[SEG-1:0], stg[k-1].res_p};
    end

    // ---- stage k register boundary ----
    // Valid bit: cleared by reset, otherwise shifts with the pipe.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p <= 1'b0;
      end else if (en) begin
        vld_p <= v_in;
      end
    end

    if (k < NSEG - 1) begin : g_skew
      logic [UW-1:0] a_p;
      logic [UW-1:0] b_p;
      logic [UW-1:0] a_up;
      logic [UW-1:0] b_up;

      if (k == 0) begin : g_up
        assign a_up = in1[WIDTH-1:SEG];
        assign b_up = b_eff[WIDTH-1:SEG];
      end else begin : g_up
        assign a_up = stg[k-1].g_skew.a_p[UW+SEG-1:SEG];
        assign b_up = stg[k-1].g_skew.b_p[UW+SEG-1:SEG];
      end

      // Carry the not-yet-summed operand segments along with their carry.
      always_ff @(posedge clk) begin
        if (en) begin
          a_p <= a_up;
          b_p <= b_up;
        end
      end

      // Partial result and inter-stage carry.
      always_ff @(posedge clk) begin
        if (en) begin
          res_p   <= res_nxt;
          carry_p <= sum[SEG];
        end
      end
    end else begin : g_last
      logic ovf_p;
      logic ovf_nxt;

      // Carry into the MSB is recovered as a^b^sum at that bit.
      assign ovf_nxt = a_seg[SEG-1] ^ b_seg[SEG-1] ^ sum[SEG-1] ^ sum[SEG];

      // Output register: cleared by reset so the idle outputs read zero.
      always_ff @(posedge clk) begin
        if (rst) begin
          res_p   <= '0;
          carry_p <= 1'b0;
          ovf_p   <= 1'b0;
        end else if (en) begin
          res_p   <= res_nxt;
          carry_p <= sum[SEG];
          ovf_p   <= ovf_nxt;
        end
      end
    end
  end

  assign out_valid = stg[NSEG-1].vld_p;
  assign out       = stg[NSEG-1].res_p;
  assign out_carry = stg[NSEG-1].carry_p;
  assign out_ovf   = stg[NSEG-1].g_last.ovf_p;

endmodule
